// File: rtl/pwm_duty_meter_if.sv
// Measurement bundle for pwm_duty_meter: the sampled PWM line going in and the
// period/high/duty report coming out.
interface pwm_duty_meter_if #(
  parameter int CNT_W = 29
);
  logic             sig_in;
  logic [CNT_W-1:0] period_count;
  logic [CNT_W-1:0] high_count;
  logic [7:0]       duty_percentage;
  logic             meas_valid;
  logic             meas_timeout;

  modport master (
    output sig_in,
    input  period_count, high_count, duty_percentage, meas_valid, meas_timeout
  );

  modport slave (
    input  sig_in,
    output period_count, high_count, duty_percentage, meas_valid, meas_timeout
  );
endinterface

// File: rtl/pwm_duty_meter.sv
// Measures period, high time and whole-percent duty of an asynchronous PWM input
// in sys_clk_in cycles, and flags stuck-high / stuck-low inputs after a timeout.
module pwm_duty_meter #(
  parameter int CNT_W       = 29,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic            sys_clk_in,
  input  logic            reset,
  pwm_duty_meter_if.slave meter_if
);
  localparam int DIV_W = CNT_W + 7;
  localparam int IT_W  = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [IT_W-1:0]  IT_LAST   = IT_W'(DIV_W - 1);

  typedef enum logic [2:0] {WAIT_RISE, HIGH, LOW, DIVIDE, DONE} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_V) ? TIMEOUT_V : v + CNT_W'(1);
  endfunction

  function automatic logic [DIV_W-1:0] times100(input logic [CNT_W-1:0] v);
    return {7'd0, v} * DIV_W'(100);
  endfunction

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_lat_q, period_lat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [IT_W-1:0]  it_q, it_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;

  logic             rise, fall;
  logic [CNT_W:0]   trial;
  logic             trial_ge;
  logic             timeout_hit;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = sat_inc(cnt_q);
    high_lat_d   = high_lat_q;
    period_lat_d = period_lat_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    it_d         = it_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    tmo_d        = tmo_q;
    trial        = {rem_q, quo_q[DIV_W-1]};
    trial_ge     = (trial >= {1'b0, period_lat_q});
    timeout_hit  = 1'b0;

    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_V) begin
          timeout_hit = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          high_lat_d = cnt_q;
          state_d    = LOW;
        end else if (cnt_q == TIMEOUT_V) begin
          timeout_hit = 1'b1;
        end
      end
      LOW: begin
        // An edge arriving together with the timeout still closes the period.
        if (rise) begin
          period_lat_d = cnt_q;
          quo_d        = times100(high_lat_q);
          rem_d        = '0;
          it_d         = '0;
          state_d      = DIVIDE;
        end else if (cnt_q == TIMEOUT_V) begin
          timeout_hit = 1'b1;
        end
      end
      DIVIDE: begin
        rem_d = trial_ge ? CNT_W'(trial - {1'b0, period_lat_q}) : trial[CNT_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], trial_ge};
        it_d  = it_q + IT_W'(1);
        // Outputs load on the last iteration so they are already visible in DONE.
        if (it_q == IT_LAST) begin
          state_d      = DONE;
          period_cnt_d = period_lat_q;
          high_cnt_d   = high_lat_q;
          duty_d       = quo_d[7:0];
          tmo_d        = 1'b0;
          valid_d      = 1'b1;
        end
      end
      DONE: begin
        state_d = WAIT_RISE;
        cnt_d   = '0;
      end
      default: begin
        state_d = WAIT_RISE;
        cnt_d   = '0;
      end
    endcase

    if (timeout_hit) begin
      state_d      = WAIT_RISE;
      cnt_d        = '0;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      duty_d       = s2_q ? 8'd100 : 8'd0;
      tmo_d        = 1'b1;
      valid_d      = 1'b1;
    end
  end

  // Control, synchronizer and reported results
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_RISE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= meter_if.sig_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      cnt_q        <= cnt_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      tmo_q        <= tmo_d;
    end
  end

  // Latches and divider datapath; always written before they are consumed
  always_ff @(posedge sys_clk_in) begin
    high_lat_q   <= high_lat_d;
    period_lat_q <= period_lat_d;
    rem_q        <= rem_d;
    quo_q        <= quo_d;
    it_q         <= it_d;
  end

  assign meter_if.period_count    = period_cnt_q;
  assign meter_if.high_count      = high_cnt_q;
  assign meter_if.duty_percentage = duty_q;
  assign meter_if.meas_valid      = valid_q;
  assign meter_if.meas_timeout    = tmo_q;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized scoreboard bench for pwm_duty_meter: the driver predicts each
// report from the waveform it produces; a monitor checks every meas_valid pulse.
module tb_pwm_duty_meter;
  localparam int CNT_W = 16;
  localparam int TMO   = 1000;
  localparam int DIV_W = CNT_W + 7;
  // drive cycle of closing rise -> meas_valid: 2 sync cycles + DIV_W + 1
  localparam int LAT   = DIV_W + 3;
  // earliest drive cycle of a rise that can start the next measurement
  localparam int REARM = DIV_W + 2;

  typedef struct {
    int p;
    int h;
    int duty;
    int tmo;
    int exp_cyc;
    int exp_gap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  bit   model_en;
  bit   meas_on;
  bit   fall_seen;
  int   start_t, fall_t, ready_t;
  logic prev;
  int   r;
  int   last_valid_cyc = -1;

  pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk_in(clk),
    .reset     (rst_n),
    .meter_if  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(bus.period_count), 0);
    chk({tag, "_high"},   int'(bus.high_count), 0);
    chk({tag, "_duty"},   int'(bus.duty_percentage), 0);
    chk({tag, "_valid"},  int'(bus.meas_valid), 0);
    chk({tag, "_tmo"},    int'(bus.meas_timeout), 0);
  endtask

  // One clock of stimulus; the model follows the waveform edge by edge.
  task automatic step(input logic v);
    @(posedge clk);
    #1;
    bus.sig_in = v;
    if (model_en) begin
      if (v && !prev) begin
        if (meas_on) begin
          sb.push_back('{cyc - start_t, fall_t - start_t,
                         ((fall_t - start_t) * 100) / (cyc - start_t),
                         0, cyc + LAT, 0});
          meas_on = 1'b0;
          ready_t = cyc + REARM;
        end else if (cyc >= ready_t) begin
          meas_on   = 1'b1;
          start_t   = cyc;
          fall_seen = 1'b0;
        end
      end else if (!v && prev && meas_on && !fall_seen) begin
        fall_t    = cyc;
        fall_seen = 1'b1;
      end
    end
    prev = v;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic periods(input int p, input int h, input int n);
    repeat (n) begin
      repeat (h) step(1'b1);
      repeat (p - h) step(1'b0);
    end
  endtask

  // Leave the DUT in WAIT_RISE with every predicted report already delivered.
  task automatic to_idle();
    idle(40);
    while (meas_on) begin
      step(1'b1);
      idle(40);
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    meas_on = 1'b0;
  endtask

  task automatic release_reset();
    bus.sig_in = 1'b0;
    prev       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ready_t = cyc;
  endtask

  // Monitor: every meas_valid pulse must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.meas_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("period_count", int'(bus.period_count), e.p);
          chk("high_count", int'(bus.high_count), e.h);
          chk("duty_percentage", int'(bus.duty_percentage), e.duty);
          chk("meas_timeout", int'(bus.meas_timeout), e.tmo);
          if (e.exp_cyc >= 0) chk("valid_cycle", cyc, e.exp_cyc);
          if (e.exp_gap > 0) chk("timeout_gap", cyc - last_valid_cyc, e.exp_gap);
        end
        last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, h;
    rst_n      = 1'b1;
    bus.sig_in = 1'b0;
    prev       = 1'b0;
    model_en   = 1'b0;
    meas_on    = 1'b0;
    ready_t    = 0;
    #2;
    assert_reset();
    chk_zero("reset");
    release_reset();
    model_en = 1'b1;
    idle(5);

    // Directed patterns, then random ones
    periods(100, 25, 4);
    periods(3, 1, 30);
    periods(10, 9, 12);
    periods(2, 1, 4);
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(300, 2);
      h = $urandom_range(p - 1, 1);
      periods(p, h, 4);
    end
    to_idle();

    // Reset while in HIGH
    repeat (10) step(1'b1);
    assert_reset();
    chk_zero("rst_high");
    release_reset();
    idle(5);
    periods(60, 20, 3);
    to_idle();

    // Reset while dividing: the prediction for the closed period is withdrawn
    periods(40, 15, 1);
    step(1'b1);
    repeat (5) step(1'b1);
    void'(sb.pop_back());
    assert_reset();
    chk_zero("rst_div");
    release_reset();
    idle(5);
    periods(80, 60, 3);
    to_idle();

    // Input stuck high from reset
    model_en = 1'b0;
    assert_reset();
    bus.sig_in = 1'b1;
    prev       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r     = cyc;
    sb.push_back('{0, 0, 100, 1, r + 1003, 0});
    sb.push_back('{0, 0, 100, 1, r + 2004, TMO + 1});
    repeat (2009) @(posedge clk);
    model_en = 1'b1;
    meas_on  = 1'b0;
    ready_t  = 0;
    step(1'b1);
    idle(40);
    periods(50, 10, 4);
    to_idle();

    // Input stuck low from reset
    model_en = 1'b0;
    assert_reset();
    release_reset();
    r = cyc;
    sb.push_back('{0, 0, 0, 1, r + 1001, 0});
    sb.push_back('{0, 0, 0, 1, r + 2002, TMO + 1});
    repeat (2010) @(posedge clk);
    #1;

    chk("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
